// File: rtl/sb_pkg.sv
// Shared issue-scoreboard types: unit codes, default latencies,
// writeback slot depth and the slot record.
package sb_pkg;

  typedef enum logic [1:0] {
    U_ALU = 2'd0,
    U_MEM = 2'd1,
    U_MUL = 2'd2,
    U_RSV = 2'd3
  } unit_e;

  localparam int SLOTS     = 5;
  localparam int LAT_ALU_D = 1;
  localparam int LAT_MEM_D = 3;
  localparam int LAT_MUL_D = 5;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } slot_t;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode-to-scoreboard issue handshake.
// The master offers an instruction; the slave answers with stall.
interface issue_scoreboard_if;
  logic       issue_valid;
  logic [4:0] issue_rs;
  logic [4:0] issue_rt;
  logic [4:0] issue_rd;
  logic       issue_we;
  logic [1:0] issue_unit;
  logic       issue_stall;

  modport master (
    output issue_valid, issue_rs, issue_rt,
    output issue_rd, issue_we, issue_unit,
    input  issue_stall
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt,
    input  issue_rd, issue_we, issue_unit,
    output issue_stall
  );
endinterface

// File: rtl/sb_wb_shiftreg.sv
// Writeback slot array: shifts toward slot 0 every cycle,
// with one insert at an arbitrary index after the shift.
module sb_wb_shiftreg
  import sb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       ins,
  input  logic [2:0] ins_idx,
  input  logic [4:0] ins_rd,
  output slot_t      head,
  output logic [SLOTS:0] occ
);

  slot_t slot [SLOTS];
  slot_t nxt  [SLOTS];

  always_comb begin
    for (int k = 0; k < SLOTS - 1; k++)
      nxt[k] = slot[k+1];
    nxt[SLOTS-1] = '0;
    for (int k = 0; k < SLOTS; k++)
      if (ins && ins_idx == 3'(k))
        nxt[k] = '{valid: 1'b1, rd: ins_rd};
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 0; k < SLOTS; k++)
        slot[k] <= '0;
    end else begin
      slot <= nxt;
    end
  end

  assign head = slot[0];

  // occ[SLOTS] is a permanently empty virtual slot
  always_comb begin
    occ = '0;
    for (int k = 0; k < SLOTS; k++)
      occ[k] = slot[k].valid;
  end

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard with RAW/WAW/structural stall logic.
// Optional macro ISSUE_SCOREBOARD_BYPASS_EN forwards slot[0] to RAW.
module issue_scoreboard
  import sb_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int LAT_ALU = LAT_ALU_D,
  parameter int LAT_MEM = LAT_MEM_D,
  parameter int LAT_MUL = LAT_MUL_D
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  issue_scoreboard_if.slave iss,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [NREG-1:0] busy
);

  slot_t            head;
  logic [SLOTS:0]   occ;
  logic [2:0]       lat;
  logic             bad_unit;
  logic             fwd_rs, fwd_rt;
  logic             raw_rs, raw_rt, waw, strc;
  logic             accept, alloc;
  logic [NREG-1:0]  busy_nxt;

  always_comb begin
    lat      = 3'd0;
    bad_unit = 1'b0;
    unique case (1'b1)
      (iss.issue_unit == U_ALU): lat = 3'(LAT_ALU);
      (iss.issue_unit == U_MEM): lat = 3'(LAT_MEM);
      (iss.issue_unit == U_MUL): lat = 3'(LAT_MUL);
      default:                   bad_unit = 1'b1;
    endcase
  end

`ifdef ISSUE_SCOREBOARD_BYPASS_EN
  assign fwd_rs = head.valid && head.rd == iss.issue_rs;
  assign fwd_rt = head.valid && head.rd == iss.issue_rt;
`else
  assign fwd_rs = 1'b0;
  assign fwd_rt = 1'b0;
`endif

  assign raw_rs = iss.issue_rs != 5'd0 &&
                  busy[iss.issue_rs] && !fwd_rs;
  assign raw_rt = iss.issue_rt != 5'd0 &&
                  busy[iss.issue_rt] && !fwd_rt;
  assign waw    = iss.issue_we && iss.issue_rd != 5'd0 &&
                  busy[iss.issue_rd];
  assign strc   = iss.issue_we && !bad_unit && occ[lat];

  assign iss.issue_stall = iss.issue_valid &&
    (raw_rs || raw_rt || waw || strc || bad_unit);

  assign accept = iss.issue_valid && !iss.issue_stall &&
                  !flush && !rst;
  assign alloc  = accept && iss.issue_we &&
                  iss.issue_rd != 5'd0;

  sb_wb_shiftreg u_wb (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .ins     (alloc),
    .ins_idx (lat - 3'd1),
    .ins_rd  (iss.issue_rd),
    .head    (head),
    .occ     (occ)
  );

  assign wb_valid = head.valid;
  assign wb_rd    = head.rd;

  // retire clears first so a same-edge allocation is never lost
  always_comb begin
    busy_nxt = busy;
    if (head.valid)
      busy_nxt[head.rd] = 1'b0;
    if (alloc)
      busy_nxt[iss.issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || flush)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard.
// Expected RAW release cycle depends on ISSUE_SCOREBOARD_BYPASS_EN.
module tb_issue_scoreboard;
  import sb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] busy;
  int          checks = 0;
  int          failures = 0;

  issue_scoreboard_if sbi ();

  issue_scoreboard #(.NREG(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .iss      (sbi.slave),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .busy     (busy)
  );

  always #5 clk = ~clk;

`ifdef ISSUE_SCOREBOARD_BYPASS_EN
  localparam int RAW_ACC = 5;
`else
  localparam int RAW_ACC = 6;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] u,
                       input logic [4:0] rd, input logic we,
                       input logic [4:0] rs, input logic [4:0] rt);
    sbi.issue_valid = v;
    sbi.issue_unit  = u;
    sbi.issue_rd    = rd;
    sbi.issue_we    = we;
    sbi.issue_rs    = rs;
    sbi.issue_rt    = rt;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 5'd0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    idle();
    step();
    step();
    rst = 1'b0;

    // reset state and independent ALU op
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_busy", busy, 32'd0);
    drive(1'b1, U_ALU, 5'd1, 1'b1, 5'd1, 5'd2);
    chk("rst_alu_stall", 32'(sbi.issue_stall), 32'd0);
    step();
    idle();
    chk("alu_wbv", 32'(wb_valid), 32'd1);
    chk("alu_wbrd", 32'(wb_rd), 32'd1);
    chk("alu_busy", busy, 32'h2);
    step();
    chk("alu_wbv_off", 32'(wb_valid), 32'd0);
    chk("alu_busy_off", busy, 32'd0);

    // MUL latency 5
    drive(1'b1, U_MUL, 5'd5, 1'b1, 5'd0, 5'd0);
    chk("mul_stall", 32'(sbi.issue_stall), 32'd0);
    step();
    idle();
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("mul_wbv_c%0d", k), 32'(wb_valid),
          (k == 5) ? 32'd1 : 32'd0);
      chk($sformatf("mul_busy_c%0d", k), busy,
          (k <= 5) ? 32'h20 : 32'd0);
      if (k == 5) chk("mul_wbrd", 32'(wb_rd), 32'd5);
      step();
    end

    // RAW on MUL result
    drive(1'b1, U_MUL, 5'd3, 1'b1, 5'd0, 5'd0);
    step();
    for (int c = 1; c <= RAW_ACC; c++) begin
      drive(1'b1, U_ALU, 5'd8, 1'b1, 5'd3, 5'd0);
      chk($sformatf("raw_stall_c%0d", c), 32'(sbi.issue_stall),
          (c < RAW_ACC) ? 32'd1 : 32'd0);
      step();
    end
    idle();
    chk("raw_wbv", 32'(wb_valid), 32'd1);
    chk("raw_wbrd", 32'(wb_rd), 32'd8);
    step();

    // structural conflict MUL vs MEM
    drive(1'b1, U_MUL, 5'd4, 1'b1, 5'd0, 5'd0);
    chk("st_mul_stall", 32'(sbi.issue_stall), 32'd0);
    step();
    idle();
    step();
    drive(1'b1, U_MEM, 5'd6, 1'b1, 5'd0, 5'd0);
    chk("st_mem_c2", 32'(sbi.issue_stall), 32'd1);
    step();
    chk("st_mem_c3", 32'(sbi.issue_stall), 32'd0);
    step();
    idle();
    chk("st_wbv_c4", 32'(wb_valid), 32'd0);
    step();
    chk("st_wbv_c5", 32'(wb_valid), 32'd1);
    chk("st_wbrd_c5", 32'(wb_rd), 32'd4);
    step();
    chk("st_wbv_c6", 32'(wb_valid), 32'd1);
    chk("st_wbrd_c6", 32'(wb_rd), 32'd6);
    step();
    chk("st_wbv_c7", 32'(wb_valid), 32'd0);

    // WAW on rd=7, then rd=0 op
    drive(1'b1, U_MUL, 5'd7, 1'b1, 5'd0, 5'd0);
    step();
    for (int c = 1; c <= 6; c++) begin
      drive(1'b1, U_ALU, 5'd7, 1'b1, 5'd0, 5'd0);
      chk($sformatf("waw_stall_c%0d", c), 32'(sbi.issue_stall),
          (c <= 5) ? 32'd1 : 32'd0);
      step();
    end
    drive(1'b1, U_ALU, 5'd0, 1'b1, 5'd1, 5'd2);
    chk("waw_wbrd", 32'(wb_rd), 32'd7);
    chk("rd0_stall", 32'(sbi.issue_stall), 32'd0);
    step();
    idle();
    chk("rd0_wbv", 32'(wb_valid), 32'd0);
    chk("rd0_busy", busy, 32'd0);

    // reserved unit and idle never stall wrongly
    drive(1'b1, U_RSV, 5'd2, 1'b1, 5'd0, 5'd0);
    chk("rsv_stall", 32'(sbi.issue_stall), 32'd1);
    step();
    idle();
    chk("rsv_busy", busy, 32'd0);
    chk("idle_stall", 32'(sbi.issue_stall), 32'd0);

    // flush with three ops in flight
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, U_MUL, 5'(9 + c), 1'b1, 5'd0, 5'd0);
      step();
    end
    drive(1'b1, U_ALU, 5'd12, 1'b1, 5'd0, 5'd0);
    chk("fl_busy_pre", busy, 32'h0000_0E00);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    for (int c = 4; c <= 8; c++) begin
      chk($sformatf("fl_wbv_c%0d", c), 32'(wb_valid), 32'd0);
      chk($sformatf("fl_busy_c%0d", c), busy, 32'd0);
      step();
    end

    // reset mid-operation drops pending writebacks
    drive(1'b1, U_MUL, 5'd13, 1'b1, 5'd0, 5'd0);
    step();
    drive(1'b1, U_MEM, 5'd14, 1'b1, 5'd0, 5'd0);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("mr_wbv_%0d", c), 32'(wb_valid), 32'd0);
      chk($sformatf("mr_busy_%0d", c), busy, 32'd0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural registers.
REQ-002 SHALL have parameters LAT_ALU/LAT_MEM/LAT_MUL, defaults 1/3/5, issue-to-writeback cycles per unit (range 1..5).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all in-flight instructions.
REQ-006 SHALL have port issue_valid  input  1  decode stage presents an instruction.
REQ-007 SHALL have ports issue_rs, issue_rt, issue_rd  input  5 each  source/destination register numbers.
REQ-008 SHALL have port issue_we  input  1  instruction writes issue_rd.
REQ-009 SHALL have port issue_unit  input  2  0=ALU, 1=MEM, 2=MUL, 3=reserved.
REQ-010 SHALL have port issue_stall  output  1  combinational; instruction not accepted this cycle.
REQ-011 SHALL have ports wb_valid (1) and wb_rd (5)  outputs  register-file write enable/address this cycle.
REQ-012 SHALL have port busy  output  NREG  per-register pending-write vector.

Function
REQ-013 SHALL accept an instruction when issue_valid=1, issue_stall=0, flush=0, rst=0.
REQ-014 SHALL keep a writeback slot array slot[0..4] (valid, rd); wb_valid/wb_rd SHALL equal slot[0] directly.
REQ-015 SHALL shift each cycle: slot[k] <= slot[k+1], slot[4] <= empty; an accepted instruction with latency L is written into slot[L-1], so wb_valid for it asserts exactly L cycles after acceptance.
REQ-016 SHALL assert issue_stall on RAW: busy[issue_rs] or busy[issue_rt] (register 0 never hazards).
REQ-017 SHALL assert issue_stall on WAW: issue_we=1 and busy[issue_rd], issue_rd!=0.
REQ-018 SHALL assert issue_stall on structural hazard: issue_we=1 and slot[L] currently valid (slot[5] treated as empty).
REQ-019 SHALL assert issue_stall for issue_unit=3; issue_stall SHALL be 0 when issue_valid=0.
REQ-020 SHALL set busy[rd] on acceptance when issue_we=1 and rd!=0; instructions with issue_we=0 or rd=0 SHALL occupy no slot.
REQ-021 SHALL clear busy[slot[0].rd] at the edge ending the cycle where slot[0] is valid.
REQ-022 SHALL, on flush, clear all slots and busy bits at the next edge; the concurrent issue is ignored; the current-cycle wb_valid still reflects slot[0].

Reset
REQ-023 SHALL, when rst=1 at a rising edge, clear all slots and busy; wb_valid=0, wb_rd=0, busy=0 thereafter; rst SHALL take priority over flush and issue.
REQ-024 SHALL behave identically for reset mid-operation: pending writebacks are dropped, never emitted.

Configuration
REQ-025 SHALL honour macro ISSUE_SCOREBOARD_BYPASS_EN: when defined, a RAW source equal to a valid slot[0].rd is not a hazard (operand forwarded from writeback); when undefined, that source stalls until the busy bit clears, one cycle later. WAW and structural rules are unchanged in both builds.

Structure
REQ-026 SHALL take unit encodings, default latencies, slot depth (5) and a slot record typedef {valid, rd} from shared package sb_pkg.
REQ-027 SHALL implement the slot array as sub-module sb_wb_shiftreg (shift, insert-at-index, occupancy query); hazard logic and busy vector stay in the top.

Verification
REQ-028 SHALL cover: rst=1 two cycles -> wb_valid=0, busy=0, issue_stall=0 for an independent ALU op.
REQ-029 SHALL cover: MUL rd=5 accepted cycle 10 -> wb_valid=1, wb_rd=5 in cycle 15 only; busy[5]=1 cycles 11-15, 0 at cycle 16.
REQ-030 SHALL cover: MUL rd=3 at cycle 0, ALU rs=3 presented from cycle 1 -> stalls through cycle 4 and accepts cycle 5 with BYPASS_EN, through cycle 5 and accepts cycle 6 without.
REQ-031 SHALL cover: MUL rd=4 cycle 0, MEM rd=6 cycle 2 -> MEM stalls (slot[3] conflict at cycle 2), accepts cycle 3, writebacks in cycles 5 and 6.
REQ-032 SHALL cover: WAW MUL rd=7 then ALU rd=7 -> ALU stalls until busy[7] clears; ALU issue with rd=0 never stalls and never asserts wb_valid.
REQ-033 SHALL cover: three ops in flight, flush=1 at cycle 3 -> busy=0 and no wb_valid from cycle 4, concurrent issue dropped.
